// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - control bundle between the multi-cycle FSM and the MIPS datapath
//
// Signals:
//   instruction  opcode field IR[31:26] (datapath -> control)
//   memReady     shared memory completes current access (datapath -> control)
//   pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite, memToReg,
//   regDst, RegWrite, ALUSrcA, ALUSrcB, ALUop, pcSource
//                datapath enables and mux selects (control -> datapath)
//   instrDone    last cycle of the current instruction
//   illegalOp    undefined opcode seen in DECODE
//   state        current FSM state code for debug
// Modports: master = control FSM, slave = datapath side.
interface multicycle_control_if;
    logic [5:0] instruction;
    logic       memReady;
    logic       pcWrite;
    logic       pcWriteCond;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       memToReg;
    logic       regDst;
    logic       RegWrite;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUop;
    logic [1:0] pcSource;
    logic       instrDone;
    logic       illegalOp;
    logic [3:0] state;

    modport master (
        input  instruction, memReady,
        output pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
               pcSource, instrDone, illegalOp, state
    );

    modport slave (
        output instruction, memReady,
        input  pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
               memToReg, regDst, RegWrite, ALUSrcA, ALUSrcB, ALUop,
               pcSource, instrDone, illegalOp, state
    );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - Moore FSM sequencing the multi-cycle MIPS datapath
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset, forces FETCH
//   bus    multicycle_control_if.master: opcode and memReady in, every
//          datapath enable/select plus instrDone, illegalOp and state out
module multicycle_control #(
    parameter logic [5:0] OP_RTYPE = 6'b000000,
    parameter logic [5:0] OP_LW    = 6'b100011,
    parameter logic [5:0] OP_SW    = 6'b101011,
    parameter logic [5:0] OP_BEQ   = 6'b000100,
    parameter logic [5:0] OP_ADDI  = 6'b001000,
    parameter logic [5:0] OP_J     = 6'b000010
) (
    input  logic                        clk,
    input  logic                        rst_n,
    multicycle_control_if.master        bus
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        ADDIEX = 4'd9,
        ADDIWB = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t curState;
    state_t nextState;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            curState <= FETCH;
        end else begin
            curState <= nextState;
        end
    end

    assign bus.state = curState;

    always_comb begin
        nextState       = FETCH;
        bus.pcWrite     = 1'b0;
        bus.pcWriteCond = 1'b0;
        bus.iorD        = 1'b0;
        bus.memRead     = 1'b0;
        bus.memWrite    = 1'b0;
        bus.irWrite     = 1'b0;
        bus.memToReg    = 1'b0;
        bus.regDst      = 1'b0;
        bus.RegWrite    = 1'b0;
        bus.ALUSrcA     = 1'b0;
        bus.ALUSrcB     = 2'b00;
        bus.ALUop       = 2'b00;
        bus.pcSource    = 2'b00;
        bus.instrDone   = 1'b0;
        bus.illegalOp   = 1'b0;

        case (curState)
            FETCH: begin
                // PC+4 is computed every fetch cycle but only committed,
                // together with the IR load, in the cycle memory delivers.
                bus.memRead = 1'b1;
                bus.ALUSrcB = 2'b01;
                bus.irWrite = bus.memReady;
                bus.pcWrite = bus.memReady;
                nextState   = bus.memReady ? DECODE : FETCH;
            end
            DECODE: begin
                // ALUOut <= PC + (imm << 2): branch target precomputed here.
                bus.ALUSrcB = 2'b11;
                case (bus.instruction)
                    OP_LW, OP_SW: nextState = MEMADR;
                    OP_RTYPE:     nextState = EXEC;
                    OP_BEQ:       nextState = BRANCH;
                    OP_ADDI:      nextState = ADDIEX;
                    OP_J:         nextState = JUMP;
                    default: begin
                        bus.illegalOp = 1'b1;
                        bus.instrDone = 1'b1;
                        nextState     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                // Opcode is re-sampled here; anything not a load/store drops
                // back to FETCH rather than touching memory.
                if (bus.instruction == OP_LW) begin
                    nextState = MEMRD;
                end else if (bus.instruction == OP_SW) begin
                    nextState = MEMWR;
                end else begin
                    nextState = FETCH;
                end
            end
            MEMRD: begin
                bus.memRead = 1'b1;
                bus.iorD    = 1'b1;
                nextState   = bus.memReady ? MEMWB : MEMRD;
            end
            MEMWB: begin
                bus.memToReg  = 1'b1;
                bus.RegWrite  = 1'b1;
                bus.instrDone = 1'b1;
                nextState     = FETCH;
            end
            MEMWR: begin
                bus.memWrite  = 1'b1;
                bus.iorD      = 1'b1;
                bus.instrDone = bus.memReady;
                nextState     = bus.memReady ? FETCH : MEMWR;
            end
            EXEC: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUop   = 2'b10;
                nextState   = ALUWB;
            end
            ALUWB: begin
                bus.regDst    = 1'b1;
                bus.RegWrite  = 1'b1;
                bus.instrDone = 1'b1;
                nextState     = FETCH;
            end
            BRANCH: begin
                bus.ALUSrcA     = 1'b1;
                bus.ALUop       = 2'b01;
                bus.pcWriteCond = 1'b1;
                bus.pcSource    = 2'b01;
                bus.instrDone   = 1'b1;
                nextState       = FETCH;
            end
            ADDIEX: begin
                bus.ALUSrcA = 1'b1;
                bus.ALUSrcB = 2'b10;
                nextState   = ADDIWB;
            end
            ADDIWB: begin
                bus.RegWrite  = 1'b1;
                bus.instrDone = 1'b1;
                nextState     = FETCH;
            end
            JUMP: begin
                bus.pcWrite   = 1'b1;
                bus.pcSource  = 2'b10;
                bus.instrDone = 1'b1;
                nextState     = FETCH;
            end
            default: begin
                // Codes 12-15: all outputs stay 0, recover to FETCH.
                nextState = FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized self-checking bench for multicycle_control
module tb_multicycle_control;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    multicycle_control_if bus();

    multicycle_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int nChecks = 0;
    int nFails  = 0;
    logic obsDone;

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nChecks++;
        if (obs !== exp) begin
            nFails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit isLegal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b001000, 6'b000010};
    endfunction

    // Expected outputs per state, written from the control table field by field.
    function automatic logic [17:0] expOut(input int st, input logic mr, input logic [5:0] op);
        logic pcW = 0, pcWC = 0, iorD = 0, mRd = 0, mWr = 0, irW = 0;
        logic m2r = 0, rDst = 0, regW = 0, srcA = 0, done = 0, ill = 0;
        logic [1:0] srcB = 0, aluop = 0, pcSrc = 0;
        case (st)
            0:  begin mRd = 1; srcB = 2'b01; irW = mr; pcW = mr; end
            1:  begin srcB = 2'b11; if (!isLegal(op)) begin ill = 1; done = 1; end end
            2:  begin srcA = 1; srcB = 2'b10; end
            3:  begin mRd = 1; iorD = 1; end
            4:  begin m2r = 1; regW = 1; done = 1; end
            5:  begin mWr = 1; iorD = 1; done = mr; end
            6:  begin srcA = 1; aluop = 2'b10; end
            7:  begin rDst = 1; regW = 1; done = 1; end
            8:  begin srcA = 1; aluop = 2'b01; pcWC = 1; pcSrc = 2'b01; done = 1; end
            9:  begin srcA = 1; srcB = 2'b10; end
            10: begin regW = 1; done = 1; end
            11: begin pcW = 1; pcSrc = 2'b10; done = 1; end
            default: ;
        endcase
        return {pcW, pcWC, iorD, mRd, mWr, irW, m2r, rDst, regW, srcA, srcB, aluop, pcSrc, done, ill};
    endfunction

    function automatic logic [17:0] obsOut();
        return {bus.pcWrite, bus.pcWriteCond, bus.iorD, bus.memRead, bus.memWrite, bus.irWrite,
                bus.memToReg, bus.regDst, bus.RegWrite, bus.ALUSrcA, bus.ALUSrcB, bus.ALUop,
                bus.pcSource, bus.instrDone, bus.illegalOp};
    endfunction

    // Drive one cycle's inputs (called just after a rising edge), check at the falling edge.
    task automatic stepCheck(input logic mr, input logic [5:0] opd, input int es);
        bus.memReady    = mr;
        bus.instruction = opd;
        @(negedge clk);
        checkEq($sformatf("state exp=%0d", es), 32'(bus.state), 32'(es));
        checkEq($sformatf("outs s%0d mr=%0b op=%b", es, mr, opd), 32'(obsOut()), 32'(expOut(es, mr, opd)));
        checkEq("memRead&memWrite", 32'(bus.memRead & bus.memWrite), 0);
        checkEq("RegWrite&pcWrite", 32'(bus.RegWrite & (bus.pcWrite | bus.pcWriteCond)), 0);
        obsDone = bus.instrDone;
        @(posedge clk);
        #1;
    endtask

    // One instruction: walk the architectural state path for the opcode,
    // dwelling in the memory states (0,3,5) while memReady is low.
    task automatic runInstr(input logic [5:0] op, input int stallCycles, input bit randMr);
        int path[5];
        int len;
        int idx = 0;
        int cyc = 0;
        int dones = 0;
        int stalled = 0;
        int es;
        logic mr;
        logic [5:0] opd;
        path[0] = 0; path[1] = 1; path[2] = 0; path[3] = 0; path[4] = 0;
        case (op)
            6'b100011: begin len = 5; path[2] = 2; path[3] = 3; path[4] = 4; end
            6'b101011: begin len = 4; path[2] = 2; path[3] = 5; end
            6'b000000: begin len = 4; path[2] = 6; path[3] = 7; end
            6'b001000: begin len = 4; path[2] = 9; path[3] = 10; end
            6'b000100: begin len = 3; path[2] = 8; end
            6'b000010: begin len = 3; path[2] = 11; end
            default:   len = 2;
        endcase
        while (idx < len && cyc < 100) begin
            es = path[idx];
            if ((es == 3 || es == 5) && stalled < stallCycles) begin
                mr = 1'b0;
                stalled++;
            end else if (randMr) begin
                mr = ($urandom_range(0, 3) != 0);
            end else begin
                mr = 1'b1;
            end
            // Opcode is only meaningful in DECODE/MEMADR; scramble it elsewhere.
            opd = (es == 1 || es == 2) ? op : 6'($urandom);
            stepCheck(mr, opd, es);
            if (obsDone) dones++;
            if (!((es == 0 || es == 3 || es == 5) && !mr)) idx++;
            cyc++;
        end
        checkEq($sformatf("completed op=%b", op), 32'(idx), 32'(len));
        checkEq($sformatf("instrDone pulses op=%b", op), 32'(dones), 1);
    endtask

    initial begin
        logic [5:0] ops[6];
        logic [5:0] o;
        ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b101011;
        ops[3] = 6'b000100; ops[4] = 6'b001000; ops[5] = 6'b000010;

        // Reset: FETCH outputs, write enables only via memReady
        rst_n = 1'b0;
        bus.memReady = 1'b0;
        bus.instruction = 6'b000000;
        #3;
        checkEq("reset state", 32'(bus.state), 0);
        checkEq("reset outs mr=0", 32'(obsOut()), 32'(expOut(0, 1'b0, 6'd0)));
        bus.memReady = 1'b1;
        #1;
        checkEq("reset outs mr=1", 32'(obsOut()), 32'(expOut(0, 1'b1, 6'd0)));
        @(posedge clk);
        #1;
        checkEq("reset held", 32'(bus.state), 0);
        rst_n = 1'b1;

        // Directed cases
        runInstr(6'b000000, 0, 1'b0);   // R-type 0,1,6,7
        runInstr(6'b100011, 3, 1'b0);   // lw with 3-cycle MEMRD stall
        runInstr(6'b101011, 0, 1'b0);   // sw 0,1,2,5
        runInstr(6'b000100, 0, 1'b0);   // beq
        runInstr(6'b000010, 0, 1'b0);   // j
        runInstr(6'b001000, 0, 1'b0);   // addi
        runInstr(6'b111111, 0, 1'b0);   // illegal

        // Reset asserted mid-stall in MEMWR
        stepCheck(1'b1, 6'b101011, 0);
        stepCheck(1'b1, 6'b101011, 1);
        stepCheck(1'b1, 6'b101011, 2);
        stepCheck(1'b0, 6'b101011, 5);
        bus.memReady = 1'b0;
        #1;
        checkEq("pre-abort memWrite", 32'(bus.memWrite), 1);
        rst_n = 1'b0;
        #1;
        checkEq("abort state", 32'(bus.state), 0);
        checkEq("abort memWrite", 32'(bus.memWrite), 0);
        checkEq("abort outs", 32'(obsOut()), 32'(expOut(0, 1'b0, 6'b101011)));
        @(posedge clk);
        #1;
        checkEq("abort held", 32'(bus.state), 0);
        rst_n = 1'b1;
        runInstr(6'b000000, 0, 1'b0);

        // Randomized instruction stream with random memReady
        for (int i = 0; i < 60; i++) begin
            int k;
            k = $urandom_range(0, 6);
            if (k == 6) begin
                do o = 6'($urandom); while (isLegal(o));
            end else begin
                o = ops[k];
            end
            runInstr(o, $urandom_range(0, 2), 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
